// File: rtl/bp_pkg.sv
// bp_pkg: shared types, counter encodings and saturating counter helpers for the branch predictor
package bp_pkg;
  localparam int BP_ADDR_W = 32;
  localparam int BP_TAG_W = 8;
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT = 2'b10;
  localparam logic [1:0] CNT_ST = 2'b11;
  typedef enum logic {INIT, RUN} bp_state_t;
  typedef struct packed {
    logic valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_ADDR_W-1:0] target;
    logic [1:0] cnt;
  } bp_entry_t;
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CNT_ST) ? CNT_ST : c + 2'd1;
  endfunction
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/bp_table.sv
// bp_table: BTB/BHT entry array; combinational lookup port, combinational peek of the update entry, one sync write port plus init sweep write
module bp_table
  import bp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_BITS = 4,
  parameter int TAG_W = 8
) (
  input  logic                CLK,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [ADDR_W-1:0]   rd_target,
  output logic [1:0]          rd_cnt,
  input  logic [IDX_BITS-1:0] wr_idx,
  output logic                cur_valid,
  output logic [TAG_W-1:0]    cur_tag,
  output logic [ADDR_W-1:0]   cur_target,
  output logic [1:0]          cur_cnt,
  input  logic                init_en,
  input  logic [IDX_BITS-1:0] init_idx,
  input  logic                wr_en,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [ADDR_W-1:0]   wr_target,
  input  logic [1:0]          wr_cnt
);
  localparam int N = 1 << IDX_BITS;
  logic [N-1:0] valid_q, valid_d;
  logic [N-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [N-1:0][ADDR_W-1:0] target_q, target_d;
  logic [N-1:0][1:0] cnt_q, cnt_d;
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_cnt = cnt_q[rd_idx];
  assign cur_valid = valid_q[wr_idx];
  assign cur_tag = tag_q[wr_idx];
  assign cur_target = target_q[wr_idx];
  assign cur_cnt = cnt_q[wr_idx];
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    target_d = target_q;
    cnt_d = cnt_q;
    if (init_en) begin
      valid_d[init_idx] = 1'b0;
      cnt_d[init_idx] = CNT_WNT;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx] = wr_tag;
      target_d[wr_idx] = wr_target;
      cnt_d[wr_idx] = wr_cnt;
    end
  end
  always_ff @(posedge CLK) begin
    valid_q <= valid_d;
    tag_q <= tag_d;
    target_q <= target_d;
    cnt_q <= cnt_d;
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + 2-bit BHT; IF lookup on pc_if -> pred_*, MEM training via upd_*, init sweep FSM drives ready
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_BITS = 4,
  parameter int TAG_W = 8,
  parameter logic [1:0] CNT_INIT = CNT_WT
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              clear,
  input  logic [ADDR_W-1:0] pc_if,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              ready
);
  bp_state_t state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  logic rd_valid, cur_valid, init_en, upd_en, upd_hit, wr_en;
  logic [TAG_W-1:0] rd_tag, cur_tag;
  logic [ADDR_W-1:0] rd_target, cur_target, wr_target;
  logic [1:0] rd_cnt, cur_cnt, wr_cnt;
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if, upd_pc};
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= INIT;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
  always_comb begin
    state_d = clear ? INIT : (state_q == RUN || &ptr_q) ? RUN : INIT;
    ptr_d = (state_q == INIT && !clear) ? ptr_q + 1'b1 : '0;
  end
  always_comb begin
    ready = state_q == RUN;
    init_en = !ready;
    upd_en = ready && upd_valid && RESET_N;
    upd_hit = cur_valid && cur_tag == upd_pc[IDX_BITS+2 +: TAG_W];
    wr_en = upd_en && (upd_taken || upd_hit);
    wr_target = upd_taken ? upd_target : cur_target;
    wr_cnt = !upd_hit ? CNT_INIT : upd_taken ? sat_inc(cur_cnt) : sat_dec(cur_cnt);
    pred_hit = ready && rd_valid && rd_tag == pc_if[IDX_BITS+2 +: TAG_W];
    pred_taken = pred_hit && rd_cnt[1];
    pred_target = pred_hit ? rd_target : pc_if + ADDR_W'(4);
  end
  bp_table #(.ADDR_W(ADDR_W), .IDX_BITS(IDX_BITS), .TAG_W(TAG_W)) u_table (
    .CLK(CLK),
    .rd_idx(pc_if[IDX_BITS+1:2]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_target(rd_target),
    .rd_cnt(rd_cnt),
    .wr_idx(upd_pc[IDX_BITS+1:2]),
    .cur_valid(cur_valid),
    .cur_tag(cur_tag),
    .cur_target(cur_target),
    .cur_cnt(cur_cnt),
    .init_en(init_en),
    .init_idx(ptr_q),
    .wr_en(wr_en),
    .wr_tag(upd_pc[IDX_BITS+2 +: TAG_W]),
    .wr_target(wr_target),
    .wr_cnt(wr_cnt)
  );
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
module tb_branch_predictor;
  logic CLK = 0, RESET_N = 0, clear = 0, upd_valid = 0, upd_taken = 0;
  logic [31:0] pc_if = 32'h40, upd_pc = 0, upd_target = 0;
  logic pred_hit, pred_taken, ready;
  logic [31:0] pred_target;
  int vectors = 0, errs = 0;
  branch_predictor dut (
    .CLK(CLK), .RESET_N(RESET_N), .clear(clear), .pc_if(pc_if),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .ready(ready)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    tick();
    upd_valid = 0;
    #1;
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tgt);
    pc_if = pc;
    #1;
    chk({tag, "_hit"}, 32'(pred_hit), 32'(h));
    chk({tag, "_taken"}, 32'(pred_taken), 32'(t));
    chk({tag, "_target"}, pred_target, tgt);
  endtask
  initial begin
    tick(); tick();
    look("rst", 32'h40, 0, 0, 32'h44);
    chk("rst_ready", 32'(ready), 0);
    RESET_N = 1;
    for (int i = 0; i < 16; i++) begin
      chk("sweep_ready", 32'(ready), 0);
      chk("sweep_target", pred_target, 32'h44);
      tick();
    end
    chk("ready_up", 32'(ready), 1);
    look("empty", 32'h40, 0, 0, 32'h44);
    upd(32'h40, 1, 32'h20);
    look("alloc", 32'h40, 1, 1, 32'h20);
    upd(32'h40, 1, 32'h20);
    upd(32'h40, 1, 32'h20);
    look("sat_hi", 32'h40, 1, 1, 32'h20);
    upd(32'h40, 0, 32'h0);
    look("dec_10", 32'h40, 1, 1, 32'h20);
    upd(32'h40, 0, 32'h0);
    look("dec_01", 32'h40, 1, 0, 32'h20);
    upd(32'h40, 0, 32'h0);
    look("dec_00", 32'h40, 1, 0, 32'h20);
    upd(32'h40, 0, 32'h0);
    look("sat_lo", 32'h40, 1, 0, 32'h20);
    upd(32'h40, 1, 32'h24);
    look("inc_01", 32'h40, 1, 0, 32'h24);
    upd(32'h44, 0, 32'h99);
    look("miss_nt", 32'h44, 0, 0, 32'h48);
    pc_if = 32'h80;
    upd_valid = 1; upd_pc = 32'h80; upd_taken = 1; upd_target = 32'h100;
    #1;
    chk("rbw_hit", 32'(pred_hit), 0);
    chk("rbw_target", pred_target, 32'h84);
    tick();
    upd_valid = 0;
    look("rbw_next", 32'h80, 1, 1, 32'h100);
    look("evicted", 32'h40, 0, 0, 32'h44);
    upd(32'h40, 1, 32'h20);
    look("realloc", 32'h40, 1, 1, 32'h20);
    upd(32'h440, 1, 32'h300);
    look("alias_old", 32'h40, 0, 0, 32'h44);
    look("alias_new", 32'h440, 1, 1, 32'h300);
    upd(32'h440, 1, 32'h500);
    look("retarget", 32'h440, 1, 1, 32'h500);
    look("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);
    clear = 1;
    tick();
    clear = 0;
    chk("clr_ready", 32'(ready), 0);
    for (int i = 0; i < 7; i++) tick();
    clear = 1;
    upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h20;
    tick();
    clear = 0; upd_valid = 0;
    pc_if = 32'h440;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("resweep_ready", 32'(ready), 0);
      chk("resweep_hit", 32'(pred_hit), 0);
      tick();
    end
    chk("resweep_up", 32'(ready), 1);
    look("clr_gone", 32'h440, 0, 0, 32'h444);
    look("clr_drop", 32'h40, 0, 0, 32'h44);
    upd(32'h40, 1, 32'h20);
    look("pre_rst", 32'h40, 1, 1, 32'h20);
    RESET_N = 0;
    upd_valid = 1; upd_pc = 32'h840; upd_taken = 1; upd_target = 32'h600;
    tick();
    RESET_N = 1; upd_valid = 0;
    chk("rst_mid_ready", 32'(ready), 0);
    for (int i = 0; i < 16; i++) tick();
    chk("rst_mid_up", 32'(ready), 1);
    look("rst_drop", 32'h840, 0, 0, 32'h844);
    look("rst_gone", 32'h40, 0, 0, 32'h44);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor (direct-mapped BTB plus 2-bit saturating BHT) for the 5-stage pipelined core.
- Sits beside the PC in IF: looks up the current PC combinationally and supplies a predicted next PC.
- Trained from the MEM stage, where branches resolve.
- Replaces static not-taken fetch and removes most flush penalties on loops.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- IDX_BITS, 4, log2 of table entries (default 16 entries).
- TAG_W, 8, stored tag bits, taken from pc[IDX_BITS+2 +: TAG_W]; must satisfy IDX_BITS+2+TAG_W <= ADDR_W.
- CNT_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- clear  in  1  synchronous table invalidate (fence.i / debug); restarts init sweep.
- pc_if  in  ADDR_W  fetch PC to look up.
- pred_hit  out  1  valid entry with matching tag found for pc_if.
- pred_taken  out  1  hit and counter[1]==1.
- pred_target  out  ADDR_W  stored target on hit, else pc_if+4.
- upd_valid  in  1  one resolved branch/jump in MEM this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual target (sum_resultado in MEM).
- ready  out  1  table initialised; predictions and updates active.

Behaviour:
- Entry: valid(1), tag(TAG_W), target(ADDR_W), cnt(2).
- idx = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+2 +: TAG_W]; pc[1:0] ignored.
- FSM states: INIT, RUN.
  - RESET_N==0 at a clock edge: state<=INIT, sweep ptr<=0, ready<=0.
  - INIT: one entry per cycle, valid<=0, cnt<=2'b01; ptr increments.
  - INIT exits to RUN on the edge that clears entry 2^IDX_BITS-1. With defaults, ready rises exactly 16 cycles after reset release.
  - clear==1 in RUN: INIT on the next edge. clear==1 in INIT: ptr<=0, sweep restarts.
  - RESET_N low mid-sweep or mid-update: restart INIT; a pending update is dropped.
- While ready==0: pred_hit=0, pred_taken=0, pred_target=pc_if+4; upd_valid ignored.
- Lookup: purely combinational from pc_if and the current table state, zero latency.
- pred_target is always defined; the core muxes it on pred_taken.
- Update, at the edge where upd_valid==1 in RUN:
  - hit & taken: cnt<=sat_inc(cnt), target<=upd_target.
  - hit & not taken: cnt<=sat_dec(cnt); target unchanged.
  - miss & taken: allocate/replace: valid<=1, tag, target, cnt<=CNT_INIT.
  - miss & not taken: no change.
- Saturation: 2'b11 stays 11 on inc; 2'b00 stays 00 on dec; no wrap.
- Same-cycle lookup and update to the same idx: the lookup returns the pre-update entry (read-before-write). The new value is visible next cycle.
- Outputs are combinational, so their reset values apply from the first post-reset cycle: pred_hit=0, pred_taken=0, pred_target=pc_if+4, ready=0.
- pc_if+4 wraps modulo 2^ADDR_W.
- Aliasing between PCs with equal idx and tag is permitted; behaviour is then the shared entry's.

Decomposition:
- Package bp_pkg holds:
  - typedef enum {INIT, RUN} bp_state_t
  - typedef struct bp_entry_t {valid, tag, target, cnt}, parametrised via localparams
  - constants CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11
  - functions sat_inc/sat_dec
- One sub-module: bp_table, the entry array with one combinational read port, one synchronous write port and the init sweep write. The top holds the FSM and the update decision.

Test Plan:
- Reset, then pc_if=0x40 held: ready=0 and pred_target=0x44 for 16 cycles; ready=1 on cycle 17; pred_hit=0.
- Update pc=0x40, taken, target=0x20: next cycle pc_if=0x40 gives hit=1, taken=1 (cnt=10), target=0x20. Two more taken updates leave cnt=11 (saturated, no wrap).
- From cnt=11, three not-taken updates to 0x40: cnt goes 10, 01, 00; pred_taken=0 after the second; a fourth update stays 00; target still 0x20.
- Same-cycle update (0x80, taken, 0x100) and lookup pc_if=0x80 on an empty entry: that cycle hit=0, target=0x84; next cycle hit=1, target=0x100.
- Alias check with defaults: an entry at 0x40 is replaced by a taken update at 0x440 (same idx, different tag). Lookup 0x40 misses; lookup 0x440 hits with the new target.
- Pulse clear (or drop RESET_N) mid-sweep at ptr=7 with upd_valid=1: ready=0, the update is ignored, the sweep restarts and all lookups miss until ready=1, 16 cycles after the restart.
